mem_rr_arbiter: RTL

- Shares one single-port memory (addr/data/we in; data/valid out) between NUM_REQ independent requesters.
- Picks one request at a time by round-robin and issues it to the memory.
- Returns read data to the owner; a missing read response is caught by a timeout.
- Sits between the requester agents and the memory instance in the top-level environment.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_rr_arbiter_rr_pick.sv | 41 ++++
 rtl/mem_rr_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the round-robin memory arbiter.
//   state_e    : arbiter FSM states (2-bit encoding)
//   DEF_*      : default parameter values used by the arbiter and its picker
//   req_id_w() : width needed to hold a requester index (never below 1)
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } state_e;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_TIMEOUT    = 8;

    function automatic int req_id_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_rr_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req_i     : request vector, one bit per requester
//   ptr_i     : index of the most recently granted requester
//   winner_o  : first requester with req set, scanning upward from ptr_i+1 and wrapping
//   any_req_o : high when at least one request is pending
// winner_o is only meaningful while any_req_o is high.
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = req_id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [ID_W-1:0]    winner_o,
    output logic               any_req_o
);

    int   idx_c;
    logic found_c;

    assign any_req_o = |req_i;

    // Scan offsets 1..NUM_REQ so the last granted requester is checked last.
    always_comb begin
        winner_o = '0;
        found_c  = 1'b0;
        idx_c    = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx_c = int'(ptr_i) + i;
            if (idx_c >= NUM_REQ) begin
                idx_c = idx_c - NUM_REQ;
            end
            if (!found_c && req_i[ID_W'(idx_c)]) begin
                found_c  = 1'b1;
                winner_o = ID_W'(idx_c);
            end
        end
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port memory between NUM_REQ requesters.
//   i_clk, i_rst_n       : clock (rising edge), asynchronous active-low reset
//   i_req/i_we           : per-requester request level and write flag
//   i_addr/i_wdata       : packed per-requester payload, requester k at slice k
//   o_gnt                : one-hot single-cycle acceptance pulse
//   o_rvalid/o_rdata     : one-hot read return pulse with its data
//   o_err                : read timeout flag, pulses together with o_rvalid
//   o_mem_*/i_mem_*      : memory-side address, write data, write enable, read data, read valid
//   o_busy               : high whenever the FSM is not in IDLE
// All outputs come straight from flops.
module mem_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ-1:0]            i_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_wdata,
    output logic [NUM_REQ-1:0]            o_gnt,
    output logic [NUM_REQ-1:0]            o_rvalid,
    output logic [DATA_WIDTH-1:0]         o_rdata,
    output logic                          o_err,
    output logic [ADDR_WIDTH-1:0]         o_mem_addr,
    output logic [DATA_WIDTH-1:0]         o_mem_data,
    output logic                          o_mem_we,
    input  logic [DATA_WIDTH-1:0]         i_mem_data,
    input  logic                          i_mem_valid,
    output logic                          o_busy
);

    localparam int REQ_ID_W = req_id_w(NUM_REQ);
    localparam int CNT_W    = $clog2(TIMEOUT);

    state_e                state_q;
    logic [REQ_ID_W-1:0]   ptr_q;
    logic [REQ_ID_W-1:0]   win_q;
    logic                  we_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [NUM_REQ-1:0]    gnt_q;
    logic [NUM_REQ-1:0]    rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_data_q;
    logic                  mem_we_q;
    logic                  busy_q;

    logic [REQ_ID_W-1:0]   pick;
    logic                  any_req;

    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

    genvar k;
    generate
        for (k = 0; k < NUM_REQ; k++) begin : g_unpack
            assign addr_arr[k]  = i_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_arr[k] = i_wdata[k*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (REQ_ID_W)
    ) u_rr_pick (
        .req_i     (i_req),
        .ptr_i     (ptr_q),
        .winner_o  (pick),
        .any_req_o (any_req)
    );

    function automatic logic [NUM_REQ-1:0] onehot(input logic [REQ_ID_W-1:0] id);
        logic [NUM_REQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    // The memory-side address/data flops double as the payload latch: they are
    // loaded at the IDLE edge and held until the next acceptance.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= REQ_ID_W'(NUM_REQ - 1);
            win_q      <= '0;
            we_q       <= 1'b0;
            cnt_q      <= '0;
            gnt_q      <= '0;
            rvalid_q   <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_we_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            gnt_q    <= '0;
            rvalid_q <= '0;
            err_q    <= 1'b0;
            mem_we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        win_q      <= pick;
                        ptr_q      <= pick;
                        we_q       <= i_we[pick];
                        mem_addr_q <= addr_arr[pick];
                        mem_data_q <= wdata_arr[pick];
                        mem_we_q   <= i_we[pick];
                        gnt_q      <= onehot(pick);
                        busy_q     <= 1'b1;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (we_q) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q   <= '0;
                        state_q <= WAIT_RD;
                    end
                end
                WAIT_RD: begin
                    // A response arriving on the final counted cycle still wins over the timeout.
                    if (i_mem_valid) begin
                        rdata_q  <= i_mem_data;
                        rvalid_q <= onehot(win_q);
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        rdata_q  <= '0;
                        rvalid_q <= onehot(win_q);
                        err_q    <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_gnt      = gnt_q;
    assign o_rvalid   = rvalid_q;
    assign o_rdata    = rdata_q;
    assign o_err      = err_q;
    assign o_mem_addr = mem_addr_q;
    assign o_mem_data = mem_data_q;
    assign o_mem_we   = mem_we_q;
    assign o_busy     = busy_q;

endmodule
